// File: rtl/ec130_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ec130_pkg                                                          |
// | Shared types and constants for the EC-130 machine-timing sequencer |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package ec130_pkg;

    localparam int NUM_PHASES = 4;
    localparam int PH_W       = $clog2(NUM_PHASES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } tgen_state_t;

endpackage
`default_nettype wire

// File: rtl/ec130_timing_gen_phase_ctr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tgen_phase_ctr                                                     |
// | Cycle-within-phase and phase-within-digit counter, held at 0 when  |
// | disabled; exposes next-state values so outputs can be registered.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tgen_phase_ctr
    import ec130_pkg::*;
#(
    parameter  int PHASE_LEN = 8,
    localparam int CW        = $clog2(PHASE_LEN)
) (
    input  logic            clk,
    input  logic            rst_l,
    input  logic            en,
    output logic [CW-1:0]   cyc_nxt,
    output logic [PH_W-1:0] ph_nxt,
    output logic            tc
);

    localparam logic [CW-1:0]   c_cyc_last = CW'(PHASE_LEN - 1);
    localparam logic [PH_W-1:0] c_ph_last  = PH_W'(NUM_PHASES - 1);

    logic [CW-1:0]   r_cyc;
    logic [PH_W-1:0] r_ph;

    assign tc = (r_cyc == c_cyc_last) && (r_ph == c_ph_last);

    always_comb begin
        cyc_nxt = '0;
        ph_nxt  = '0;
        if (en) begin
            if (r_cyc == c_cyc_last) begin
                cyc_nxt = '0;
                ph_nxt  = tc ? '0 : r_ph + PH_W'(1);
            end else begin
                cyc_nxt = r_cyc + CW'(1);
                ph_nxt  = r_ph;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_cyc <= '0;
            r_ph  <= '0;
        end else begin
            r_cyc <= cyc_nxt;
            r_ph  <= ph_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ec130_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ec130_timing_gen                                                   |
// | Four-phase digit-time sequencer with digit counter, word boundary  |
// | flag, free-run and single-digit-step modes.                        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module ec130_timing_gen
    import ec130_pkg::*;
#(
    parameter int PHASE_LEN = 8,
    parameter int PULSE_W   = 2,
    parameter int DIGITS    = 16,
    parameter int DW        = $clog2(DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic                  run,
    input  logic                  step_req,
    input  logic                  digit_clr,
    output logic [NUM_PHASES-1:0] phase_p,
    output logic [DW-1:0]         digit,
    output logic                  digit_end,
    output logic                  word_end,
    output logic                  step_ack,
    output logic                  busy
);

    localparam int              CW           = $clog2(PHASE_LEN);
    localparam logic [CW-1:0]   c_cyc_last   = CW'(PHASE_LEN - 1);
    localparam logic [CW-1:0]   c_pulse_w    = CW'(PULSE_W);
    localparam logic [PH_W-1:0] c_ph_last    = PH_W'(NUM_PHASES - 1);
    localparam logic [DW-1:0]   c_digit_last = DW'(DIGITS - 1);

    tgen_state_t           r_state;
    tgen_state_t           w_state_nxt;
    logic                  r_busy;
    logic [NUM_PHASES-1:0] r_phase_p;
    logic [DW-1:0]         r_digit;
    logic                  r_digit_end;
    logic                  r_word_end;
    logic                  r_step_ack;

    logic [CW-1:0]         w_cyc_nxt;
    logic [PH_W-1:0]       w_ph_nxt;
    logic                  w_tc;
    logic                  w_dend;
    logic                  w_busy_nxt;
    logic                  w_dend_nxt;
    logic [NUM_PHASES-1:0] w_phase_nxt;
    logic [DW-1:0]         w_digit_nxt;

    tgen_phase_ctr #(
        .PHASE_LEN (PHASE_LEN)
    ) u_phase_ctr (
        .clk     (clk),
        .rst_l   (rst_l),
        .en      (r_busy),
        .cyc_nxt (w_cyc_nxt),
        .ph_nxt  (w_ph_nxt),
        .tc      (w_tc)
    );

    assign w_dend = r_busy && w_tc;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (run)
                    w_state_nxt = RUN;
                else if (step_req)
                    w_state_nxt = STEP;
            end
            RUN: begin
                if (w_dend && !run)
                    w_state_nxt = IDLE;
            end
            STEP: begin
                if (w_dend)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_digit_nxt = r_digit;
        if (w_dend)
            w_digit_nxt = (r_digit == c_digit_last) ? '0 : r_digit + DW'(1);
        else if ((r_state == IDLE) && digit_clr)
            w_digit_nxt = '0;
    end

    // Outputs are registered from next-cycle values so each is a clean flop.
    assign w_busy_nxt = (w_state_nxt != IDLE);
    assign w_dend_nxt = w_busy_nxt && (w_cyc_nxt == c_cyc_last) && (w_ph_nxt == c_ph_last);

    for (genvar k = 0; k < NUM_PHASES; k++) begin : g_phase
        assign w_phase_nxt[k] = w_busy_nxt && (w_ph_nxt == PH_W'(k)) && (w_cyc_nxt < c_pulse_w);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_phase_p   <= '0;
            r_digit     <= '0;
            r_digit_end <= 1'b0;
            r_word_end  <= 1'b0;
            r_step_ack  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= w_busy_nxt;
            r_phase_p   <= w_phase_nxt;
            r_digit     <= w_digit_nxt;
            r_digit_end <= w_dend_nxt;
            r_word_end  <= w_dend_nxt && (w_digit_nxt == c_digit_last);
            r_step_ack  <= w_dend_nxt && (w_state_nxt == STEP);
        end
    end

    assign phase_p   = r_phase_p;
    assign digit     = r_digit;
    assign digit_end = r_digit_end;
    assign word_end  = r_word_end;
    assign step_ack  = r_step_ack;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ec130_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ec130_timing_gen                                                |
// | Scoreboard bench: stimulus queues expected pulse/digit-end events, |
// | a negedge monitor pops and compares them as the DUT emits them.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_ec130_timing_gen;

    localparam int PLEN = 8;
    localparam int PW   = 2;

    logic       clk = 1'b0;
    logic       rst_l;
    logic       run;
    logic       step_req;
    logic       digit_clr;
    logic [3:0] phase_p;
    logic [3:0] digit;
    logic       digit_end;
    logic       word_end;
    logic       step_ack;
    logic       busy;

    ec130_timing_gen dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .run       (run),
        .step_req  (step_req),
        .digit_clr (digit_clr),
        .phase_p   (phase_p),
        .digit     (digit),
        .digit_end (digit_end),
        .word_end  (word_end),
        .step_ack  (step_ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 0 = phase pulse rise, 1 = digit end
        int cyc;
        int val;    // phase index or digit value
        int we;
        int ack;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc_n    = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Queue the events of one digit whose first busy cycle is observed at base.
    task automatic push_digit(input int base, input int dval, input int ack, input int nph = 4);
        ev_t e;
        for (int k = 0; k < nph; k++) begin
            e.kind = 0; e.cyc = base + PLEN * k; e.val = k; e.we = 0; e.ack = 0;
            exp_q.push_back(e);
        end
        if (nph == 4) begin
            e.kind = 1; e.cyc = base + 4 * PLEN - 1; e.val = dval;
            e.we = (dval == 15) ? 1 : 0; e.ack = ack;
            exp_q.push_back(e);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor
    int  prev_pp = 0;
    int  plen    = 0;
    int  pp;
    int  idx;
    ev_t mev;

    always @(negedge clk) begin
        if (!rst_l) begin
            prev_pp = 0;
            plen    = 0;
        end else begin
            pp = int'(phase_p);
            if (prev_pp != 0 && pp != prev_pp)
                chk("pulse_width", plen, PW);
            if (pp != 0 && pp == prev_pp)
                plen++;
            else if (pp != 0)
                plen = 1;
            else
                plen = 0;

            if (pp != 0 && pp != prev_pp) begin
                chk("phase_onehot", $countones(phase_p), 1);
                idx = 0;
                for (int k = 0; k < 4; k++)
                    if (phase_p[k]) idx = k;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", pp, 0);
                end else begin
                    mev = exp_q.pop_front();
                    chk("pulse_kind", 0, mev.kind);
                    chk("pulse_phase", idx, mev.val);
                    chk("pulse_cycle", cyc_n, mev.cyc);
                end
            end

            if (digit_end) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_digit_end", 1, 0);
                end else begin
                    mev = exp_q.pop_front();
                    chk("dend_kind", 1, mev.kind);
                    chk("dend_cycle", cyc_n, mev.cyc);
                    chk("dend_digit", int'(digit), mev.val);
                    chk("dend_word_end", int'(word_end), mev.we);
                    chk("dend_step_ack", int'(step_ack), mev.ack);
                    chk("dend_busy", int'(busy), 1);
                end
            end else if (word_end || step_ack) begin
                chk("stray_end_flags", int'({word_end, step_ack}), 0);
            end
            prev_pp = pp;
        end
    end

    int n;

    initial begin
        rst_l = 1'b0; run = 1'b0; step_req = 1'b0; digit_clr = 1'b0;
        tick(3);
        chk("rst_phase_p", int'(phase_p), 0);
        chk("rst_digit", int'(digit), 0);
        chk("rst_digit_end", int'(digit_end), 0);
        chk("rst_word_end", int'(word_end), 0);
        chk("rst_step_ack", int'(step_ack), 0);
        chk("rst_busy", int'(busy), 0);
        rst_l = 1'b1;
        tick(2);

        // Single run digit
        n = cyc_n; run = 1'b1; push_digit(n + 1, 0, 0);
        tick(1); run = 1'b0;
        chk("start_busy", int'(busy), 1);
        tick(31);
        chk("last_busy", int'(busy), 1);
        tick(1);
        chk("t1_busy_drop", int'(busy), 0);
        chk("t1_digit", int'(digit), 1);
        chk("t1_phase_idle", int'(phase_p), 0);

        // Free run through the word boundary, digits 1..15
        n = cyc_n; run = 1'b1;
        for (int i = 0; i < 15; i++) push_digit(n + 1 + 32 * i, 1 + i, 0);
        tick(470); run = 1'b0;
        tick(11);
        chk("t2_busy_drop", int'(busy), 0);
        chk("t2_digit_wrap", int'(digit), 0);

        // Single step; a second request during STEP is ignored
        n = cyc_n; step_req = 1'b1; push_digit(n + 1, 0, 1);
        tick(1); step_req = 1'b0;
        tick(9); step_req = 1'b1;
        tick(1); step_req = 1'b0;
        tick(23);
        chk("t3_busy_drop", int'(busy), 0);
        chk("t3_digit", int'(digit), 1);
        tick(40);
        chk("t3_still_idle", int'(busy), 0);

        // run and step together; run dropped at digit cycle 5
        n = cyc_n; run = 1'b1; step_req = 1'b1; push_digit(n + 1, 1, 0);
        tick(1); step_req = 1'b0;
        tick(5); run = 1'b0;
        tick(27);
        chk("t4_busy_drop", int'(busy), 0);
        chk("t4_digit", int'(digit), 2);

        // Asynchronous reset at phase 2, cycle 1
        n = cyc_n; run = 1'b1; push_digit(n + 1, 2, 0, 3);
        tick(1); run = 1'b0;
        tick(17);
        chk("t6_pre_reset_phase", int'(phase_p), 4);
        #2 rst_l = 1'b0;
        #1;
        chk("t6_rst_phase_p", int'(phase_p), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_digit", int'(digit), 0);
        chk("t6_rst_digit_end", int'(digit_end), 0);
        tick(1); rst_l = 1'b1;
        tick(2);
        n = cyc_n; run = 1'b1; push_digit(n + 1, 0, 0);
        tick(1); run = 1'b0;
        chk("t6_restart_phase", int'(phase_p), 1);
        tick(32);
        chk("t6_digit", int'(digit), 1);

        // digit_clr ignored while running
        n = cyc_n; run = 1'b1; push_digit(n + 1, 1, 0);
        tick(2); digit_clr = 1'b1; run = 1'b0;
        tick(18); digit_clr = 1'b0;
        tick(13);
        chk("t5_clr_in_run", int'(digit), 2);

        // Advance to digit 7, then clear in IDLE
        n = cyc_n; run = 1'b1;
        for (int i = 0; i < 5; i++) push_digit(n + 1 + 32 * i, 2 + i, 0);
        tick(140); run = 1'b0;
        tick(21);
        chk("t5_busy_drop", int'(busy), 0);
        chk("t5_digit7", int'(digit), 7);
        digit_clr = 1'b1;
        tick(1); digit_clr = 1'b0;
        chk("t5_clr_in_idle", int'(digit), 0);

        tick(5);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ec130_timing_gen.md
# ec130_timing_gen

Machine-timing sequencer for the EC-130 model. It divides the system clock into digit times of four phases. For each phase it drives a level pulse that feeds the `tog_p`/`set_p`/`rst_p` inputs of the flip-flop array. It also maintains the digit counter, flags digit and word boundaries, and supports free-run and single-digit-step operation.

## Interface

Parameters:
- `PHASE_LEN`, default 8: clk cycles per phase; legal range ≥ 2.
- `PULSE_W`, default 2: cycles each phase pulse is held high; must satisfy 1 ≤ `PULSE_W` < `PHASE_LEN`, so every pulse has a low gap that downstream edge detectors can see.
- `DIGITS`, default 16: digit times per word; legal range ≥ 2.
- `DW`, default `$clog2(DIGITS)`: width of the `digit` output.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_l`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; free-run while high.
- `step_req`  in  1  level or pulse; requests exactly one digit time when idle.
- `digit_clr`  in  1  synchronous clear of `digit`; honored in IDLE only.
- `phase_p`  out  4  phase pulses; bit k high during phase k for cycles 0..`PULSE_W`-1.
- `digit`  out  `DW`  current digit index, 0..`DIGITS`-1.
- `digit_end`  out  1  high for 1 cycle on the last cycle of phase 3.
- `word_end`  out  1  high for 1 cycle, coincident with `digit_end` when `digit` = `DIGITS`-1.
- `step_ack`  out  1  high for 1 cycle, coincident with `digit_end` of a step digit.
- `busy`  out  1  high in RUN and STEP.

## Operation

- Internal counters: `cyc` counts 0..`PHASE_LEN`-1 and `ph` counts 0..3; both are held at 0 in IDLE.
- FSM states and transitions:
  - IDLE:
    - If `run`=1: go to RUN.
    - Else if `step_req`=1: go to STEP.
    - When both are high, `run` wins and no `step_ack` is produced.
  - RUN: sequence digits continuously. At `digit_end`, if `run`=0 go to IDLE, otherwise stay in RUN.
  - STEP: sequence one digit. At `digit_end`, assert `step_ack` and go to IDLE. `run` and `step_req` are ignored during STEP.
- A digit that has started always completes. Dropping `run` mid-digit never truncates a phase and never shortens a pulse.
- Digit advance: on every `digit_end`, `digit` increments. When `digit` = `DIGITS`-1 it wraps to 0 and `word_end` is asserted.
- `digit_clr` is honored only in IDLE and sets `digit` to 0. In RUN and STEP it is ignored.
- `step_req` is ignored while `busy`=1. A request that is still high when STEP returns to IDLE starts another step; requesters drop `step_req` on `step_ack`.
- `phase_p[k]` = busy & (`ph`==k) & (`cyc`<`PULSE_W`). The outputs are registered and glitch-free, and at most one bit is high at a time.

## Timing

- Reset values: `phase_p`=0, `digit`=0, `digit_end`=0, `word_end`=0, `step_ack`=0, `busy`=0, state IDLE. Reset takes effect immediately and asynchronously, including mid-digit; the partial digit is abandoned.
- Start latency: `run` or `step_req` is sampled high in IDLE at edge t. At t+1, `busy`=1 and `phase_p[0]`=1.
- Digit time is exactly 4·`PHASE_LEN` cycles. Phase k's pulse rises at digit-relative cycle k·`PHASE_LEN`.
- Back-to-back digits in RUN have no idle cycle. `phase_p[0]` rises on the cycle after `digit_end`.
- Stop: `digit_end` is the last cycle with `busy`=1. On the next cycle `busy`=0 and all outputs are 0 except `digit`.
- The new `digit` value is visible on the cycle after `digit_end`.

## Structure

- Shared package `ec130_pkg` holds:
  - the state enum `tgen_state_t` with values IDLE, RUN and STEP;
  - the constant `NUM_PHASES`=4.
- One sub-module is natural: `tgen_phase_ctr`, the `cyc`/`ph` counter with a terminal-count output.
- The FSM, digit counter and output registers live in the top module.

## Test plan

- Reset, then `run`=1 for 1 cycle (defaults) → exactly one digit:
  - `phase_p` one-hot pulses of 2 cycles at offsets 0, 8, 16, 24;
  - `digit_end` at cycle 32 after start;
  - `digit` goes 0→1 and `busy` drops at cycle 33.
- `run` held for 16 digits → `word_end` fires exactly once, with `digit_end` when `digit`=15. `digit` reads 0 afterwards, and there is no gap cycle between digits.
- `step_req` pulsed in IDLE → one digit, `step_ack` coincident with `digit_end`. A second `step_req` during STEP is ignored, giving one ack total.
- `run`=1 and `step_req`=1 in the same cycle → RUN entered, no `step_ack`. Dropping `run` at digit cycle 5 → the digit completes all four pulses, then IDLE.
- `digit_clr` asserted in RUN → no effect. Asserted in IDLE with `digit`=7 → `digit`=0 on the next cycle.
- `rst_l` low at phase 2 cycle 1 → all outputs 0 immediately. After release, `run`=1 → restart from `phase_p[0]` with `digit`=0.
